// File: rtl/wbn_pkg.sv
// wbn_pkg: shared types and helpers for the wbn_arb Wishbone arbiter.
// The ABORT state exists only when WBN_ARB_TIMEOUT_EN is defined.
package wbn_pkg;

`ifdef WBN_ARB_TIMEOUT_EN
    typedef enum logic [1:0] {IDLE, BUSY, ABORT} wbn_arb_state_t;
`else
    typedef enum logic [1:0] {IDLE, BUSY} wbn_arb_state_t;
`endif

    // Index of the set bit in a one-hot vector of up to 32 bits.
    function automatic logic [4:0] oh2idx(input logic [31:0] oh);
        oh2idx = '0;
        for (int i = 0; i < 32; i++)
            if (oh[i]) oh2idx = 5'(i);
    endfunction

endpackage

// File: rtl/wbn_arb_rr.sv
// wbn_arb_rr: combinational rotating-priority encoder; search starts at ptr and wraps mod N.
module wbn_arb_rr
    import wbn_pkg::*;
#(
    parameter  int N  = 2,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  win,
    output logic [IW-1:0] idx,
    output logic          valid
);

    logic [IW-1:0] j;

    // Walk from the lowest priority up so the request nearest ptr overwrites the rest.
    always_comb begin
        win = '0;
        j   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = IW'((int'(ptr) + k) % N);
            if (req[j]) begin
                win    = '0;
                win[j] = 1'b1;
            end
        end
        idx   = IW'(oh2idx(32'(win)));
        valid = |req;
    end

endmodule

// File: rtl/wbn_arb.sv
// wbn_arb: round-robin Wishbone B3 classic arbiter granting one slave per bus cycle to N masters.
// Define WBN_ARB_TIMEOUT_EN to add a watchdog that aborts stalled cycles with m_err after TO cycles.
module wbn_arb
    import wbn_pkg::*;
#(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int SW = DW / 8,
    parameter int TO = 256
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N-1:0]    m_cyc,
    input  logic [N-1:0]    m_we,
    input  logic [N-1:0]    m_stb,
    input  logic [N*AW-1:0] m_adr,
    input  logic [N*SW-1:0] m_sel,
    input  logic [N*DW-1:0] m_dat_w,
    output logic [N*DW-1:0] m_dat_r,
    output logic [N-1:0]    m_ack,
    output logic [N-1:0]    m_err,
    output logic [N-1:0]    m_rty,
    output logic            s_cyc,
    output logic            s_we,
    output logic            s_stb,
    output logic [AW-1:0]   s_adr,
    output logic [SW-1:0]   s_sel,
    output logic [DW-1:0]   s_dat_w,
    input  logic [DW-1:0]   s_dat_r,
    input  logic            s_ack,
    input  logic            s_err,
    input  logic            s_rty,
    output logic [N-1:0]    gnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    wbn_arb_state_t state, state_n;
    logic [IW-1:0]  ptr, own, win_idx;
    logic [N-1:0]   win;
    logic           win_vld, busy, to_hit;

    wbn_arb_rr #(.N(N)) u_rr (
        .req   (m_cyc),
        .ptr   (ptr),
        .win   (win),
        .idx   (win_idx),
        .valid (win_vld)
    );

    // Only BUSY drives the slave, so reset and ABORT silence the bus at once.
    assign busy    = (state == BUSY);
    assign s_cyc   = busy & m_cyc[own];
    assign s_stb   = s_cyc & m_stb[own];
    assign s_we    = s_cyc & m_we[own];
    assign s_adr   = busy ? m_adr[own*AW +: AW] : '0;
    assign s_sel   = busy ? m_sel[own*SW +: SW] : '0;
    assign s_dat_w = busy ? m_dat_w[own*DW +: DW] : '0;
    assign m_dat_r = {N{s_dat_r}};

`ifdef WBN_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TO + 1);
    logic [CW-1:0] cnt;
    logic          stall;

    assign stall  = s_stb & ~(s_ack | s_err | s_rty);
    assign to_hit = stall & (cnt == CW'(TO - 1));

    always_ff @(posedge clk or negedge rst)
        if (!rst) cnt <= '0;
        else      cnt <= stall ? cnt + 1'b1 : '0;
`else
    assign to_hit = 1'b0;
`endif

    always_comb begin
        m_ack = '0;
        m_err = '0;
        m_rty = '0;
        if (s_cyc) begin
            m_ack[own] = s_ack;
            m_err[own] = s_err | to_hit;
            m_rty[own] = s_rty;
        end
    end

    always_comb begin
        state_n = state;
        if (state == IDLE)       state_n = win_vld ? BUSY : IDLE;
        else if (!m_cyc[own])    state_n = IDLE;
`ifdef WBN_ARB_TIMEOUT_EN
        else if (to_hit)         state_n = ABORT;
`endif
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            state <= IDLE;
            gnt   <= '0;
            own   <= '0;
            ptr   <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && win_vld) begin
                gnt <= win;
                own <= win_idx;
                ptr <= (win_idx == IW'(N - 1)) ? '0 : win_idx + 1'b1;
            end else if (state_n == IDLE) begin
                gnt <= '0;
            end
        end

endmodule

// File: tb/tb_wbn_arb.sv
// tb_wbn_arb: self-checking bench for wbn_arb (N=2, TO=8); grants and terminations are scoreboarded.
// The watchdog scenario runs only when WBN_ARB_TIMEOUT_EN is defined.
module tb_wbn_arb;

    localparam int N = 2, AW = 32, DW = 32, SW = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [N-1:0]    m_cyc, m_we, m_stb, m_ack, m_err, m_rty, gnt;
    logic [N*AW-1:0] m_adr;
    logic [N*SW-1:0] m_sel;
    logic [N*DW-1:0] m_dat_w, m_dat_r;
    logic            s_cyc, s_we, s_stb, s_ack, s_err, s_rty;
    logic [AW-1:0]   s_adr;
    logic [SW-1:0]   s_sel;
    logic [DW-1:0]   s_dat_w, s_dat_r;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [N-1:0] ack;
        logic [N-1:0] err;
        logic [N-1:0] rty;
    } term_t;

    term_t        exp_term[$];
    logic [N-1:0] exp_gnt[$];
    logic [N-1:0] prev_gnt = '0;
    term_t        got_t, want_t;
    logic [N-1:0] want_g;

    always #5 clk = ~clk;

    wbn_arb #(.N(N), .AW(AW), .DW(DW), .SW(SW), .TO(8)) dut (
        .clk(clk), .rst(rst),
        .m_cyc(m_cyc), .m_we(m_we), .m_stb(m_stb), .m_adr(m_adr), .m_sel(m_sel),
        .m_dat_w(m_dat_w), .m_dat_r(m_dat_r), .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty),
        .s_cyc(s_cyc), .s_we(s_we), .s_stb(s_stb), .s_adr(s_adr), .s_sel(s_sel),
        .s_dat_w(s_dat_w), .s_dat_r(s_dat_r), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
        .gnt(gnt)
    );

    // Termination scoreboard: every nonzero termination must match the next expectation.
    always @(negedge clk) begin
        got_t = {m_ack, m_err, m_rty};
        if (got_t != '0) begin
            checks++;
            if (exp_term.size() == 0) begin
                errors++;
                $display("FAIL term_unexpected: got ack=%b err=%b rty=%b, none expected", m_ack, m_err, m_rty);
            end else begin
                want_t = exp_term.pop_front();
                if (got_t !== want_t) begin
                    errors++;
                    $display("FAIL term_route: got ack=%b err=%b rty=%b want ack=%b err=%b rty=%b",
                             m_ack, m_err, m_rty, want_t.ack, want_t.err, want_t.rty);
                end
            end
        end
    end

    // Grant scoreboard: each new nonzero grant must match the next expected owner.
    always @(negedge clk) begin
        if (gnt !== prev_gnt && gnt !== '0) begin
            checks++;
            if (exp_gnt.size() == 0) begin
                errors++;
                $display("FAIL gnt_unexpected: got %b, none expected", gnt);
            end else begin
                want_g = exp_gnt.pop_front();
                if (gnt !== want_g) begin
                    errors++;
                    $display("FAIL gnt_order: got %b want %b", gnt, want_g);
                end
            end
        end
        prev_gnt = gnt;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        m_cyc = '0; m_we = '0; m_stb = '0; m_adr = '0; m_sel = '0; m_dat_w = '0;
        s_dat_r = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
        tick;
        m_cyc = 2'b11; m_stb = 2'b11; s_ack = 1'b1;
        tick;
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL reset_gnt: got %b want 00", gnt); end
        checks++; if ({s_cyc, s_stb} !== 2'b00) begin errors++; $display("FAIL reset_bus: got cyc/stb %b want 00", {s_cyc, s_stb}); end
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL reset_ack: got %b want 00", m_ack); end
        tick;
        rst = 1'b1; m_cyc = '0; m_stb = '0; s_ack = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_single;
        tick;
        m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b10;
        m_adr[AW +: AW] = 32'h10; m_sel[SW +: SW] = 4'hf; m_dat_w[DW +: DW] = 32'hcafe0001;
        exp_gnt.push_back(2'b10);
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_latency: got %b want 00", gnt); end
        tick;
        @(negedge clk);
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL single_gnt: got %b want 10", gnt); end
        checks++; if ({s_cyc, s_stb, s_we} !== 3'b111) begin errors++; $display("FAIL single_ctl: got %b want 111", {s_cyc, s_stb, s_we}); end
        checks++; if (s_adr !== 32'h10) begin errors++; $display("FAIL single_adr: got %h want 00000010", s_adr); end
        checks++; if (s_dat_w !== 32'hcafe0001 || s_sel !== 4'hf) begin errors++; $display("FAIL single_wdata: got %h/%h want cafe0001/f", s_dat_w, s_sel); end
        tick;
        @(negedge clk);
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL single_early_ack: got %b want 00", m_ack); end
        tick;
        s_ack = 1'b1; s_dat_r = 32'h12345678;
        exp_term.push_back(term_t'({2'b10, 2'b00, 2'b00}));
        @(negedge clk);
        checks++; if (m_ack[0] !== 1'b0) begin errors++; $display("FAIL single_ack0: got %b want 0", m_ack[0]); end
        checks++; if (m_dat_r !== {2{32'h12345678}}) begin errors++; $display("FAIL single_rdata: got %h want 1234567812345678", m_dat_r); end
        tick;
        s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
        @(negedge clk);
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL single_release_cyc: got %b want 0", s_cyc); end
        tick;
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL single_release_gnt: got %b want 00", gnt); end
    endtask

    task automatic test_contention;
        rst = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        m_cyc = 2'b11;
        exp_gnt.push_back(2'b01);
        tick;
        m_stb = 2'b01; s_ack = 1'b1;
        exp_term.push_back(term_t'({2'b01, 2'b00, 2'b00}));
        @(negedge clk);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL cont_first: got %b want 01", gnt); end
        tick;
        s_ack = 1'b0; m_stb = '0; m_cyc = 2'b10;
        exp_gnt.push_back(2'b10);
        @(negedge clk);
        checks++; if (s_cyc !== 1'b0) begin errors++; $display("FAIL cont_drop_cyc: got %b want 0", s_cyc); end
        tick;
        @(negedge clk);
        checks++; if ({gnt, s_cyc} !== 3'b000) begin errors++; $display("FAIL cont_idle_gap: got gnt/cyc %b want 000", {gnt, s_cyc}); end
        tick;
        @(negedge clk);
        checks++; if ({gnt, s_cyc} !== 3'b101) begin errors++; $display("FAIL cont_second: got gnt/cyc %b want 101", {gnt, s_cyc}); end
        tick;
        m_cyc = 2'b01;
        tick;
        m_cyc = 2'b11;
        exp_gnt.push_back(2'b01);
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL cont_idle2: got %b want 00", gnt); end
        tick;
        @(negedge clk);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL cont_third: got %b want 01", gnt); end
        tick;
        m_cyc = '0;
        tick;
        tick;
    endtask

    task automatic test_locked;
        tick;
        m_cyc = 2'b01;
        exp_gnt.push_back(2'b01);
        tick;
        m_cyc = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick;
            m_stb = 2'b01; s_ack = 1'b1; m_adr[0 +: AW] = 32'h100 + 32'(i * 4);
            exp_term.push_back(term_t'({2'b01, 2'b00, 2'b00}));
            @(negedge clk);
            checks++; if (gnt !== 2'b01 || s_adr !== 32'h100 + 32'(i * 4)) begin errors++; $display("FAIL locked_beat%0d: got gnt=%b adr=%h want 01/%h", i, gnt, s_adr, 32'h100 + 32'(i * 4)); end
            tick;
            m_stb = '0; s_ack = 1'b0;
            @(negedge clk);
            checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL locked_hold%0d: got %b want 01", i, gnt); end
        end
        tick;
        m_cyc = 2'b10;
        exp_gnt.push_back(2'b10);
        tick;
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL locked_gap: got %b want 00", gnt); end
        tick;
        @(negedge clk);
        checks++; if (gnt !== 2'b10) begin errors++; $display("FAIL locked_next: got %b want 10", gnt); end
        tick;
        m_cyc = '0;
        tick;
        tick;
    endtask

    task automatic test_reset_mid;
        tick;
        m_cyc = 2'b01;
        exp_gnt.push_back(2'b01);
        tick;
        m_stb = 2'b01;
        @(negedge clk);
        checks++; if ({gnt, s_stb} !== 3'b011) begin errors++; $display("FAIL rmid_busy: got gnt/stb %b want 011", {gnt, s_stb}); end
        tick;
        rst = 1'b0; s_ack = 1'b1;
        #1;
        checks++; if ({s_cyc, s_stb, gnt} !== 4'b0000) begin errors++; $display("FAIL rmid_async: got cyc/stb/gnt %b want 0000", {s_cyc, s_stb, gnt}); end
        checks++; if (m_ack !== 2'b00) begin errors++; $display("FAIL rmid_ack: got %b want 00", m_ack); end
        tick;
        m_cyc = 2'b11; m_stb = '0; s_ack = 1'b0;
        tick;
        rst = 1'b1;
        exp_gnt.push_back(2'b01);
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL rmid_release: got %b want 00", gnt); end
        tick;
        @(negedge clk);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL rmid_first: got %b want 01", gnt); end
        tick;
        m_cyc = '0;
        tick;
        tick;
    endtask

    task automatic test_err_rty;
        tick;
        m_cyc = 2'b11;
        exp_gnt.push_back(2'b10);
        tick;
        m_stb = 2'b10; s_rty = 1'b1;
        exp_term.push_back(term_t'({2'b00, 2'b00, 2'b10}));
        @(negedge clk);
        checks++; if (gnt !== 2'b10 || m_rty[0] !== 1'b0) begin errors++; $display("FAIL rty_route: got gnt=%b rty=%b want 10/10", gnt, m_rty); end
        tick;
        s_rty = 1'b0; s_err = 1'b1;
        exp_term.push_back(term_t'({2'b00, 2'b10, 2'b00}));
        @(negedge clk);
        checks++; if (m_err !== 2'b10 || m_rty !== 2'b00) begin errors++; $display("FAIL err_route: got err=%b rty=%b want 10/00", m_err, m_rty); end
        tick;
        s_err = 1'b0; m_cyc = '0; m_stb = '0;
        tick;
        tick;
    endtask

    task automatic test_latency_drop;
        tick;
        m_cyc = 2'b01; m_stb = 2'b01;
        exp_gnt.push_back(2'b01);
        tick;
        m_cyc = '0; m_stb = '0;
        @(negedge clk);
        checks++; if ({gnt, s_cyc, s_stb} !== 4'b0100) begin errors++; $display("FAIL ldrop_busy: got gnt/cyc/stb %b want 0100", {gnt, s_cyc, s_stb}); end
        tick;
        @(negedge clk);
        checks++; if ({gnt, s_stb} !== 3'b000) begin errors++; $display("FAIL ldrop_idle: got gnt/stb %b want 000", {gnt, s_stb}); end
        tick;
    endtask

`ifdef WBN_ARB_TIMEOUT_EN
    task automatic test_timeout;
        tick;
        m_cyc = 2'b01;
        exp_gnt.push_back(2'b01);
        tick;
        m_stb = 2'b01;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) exp_term.push_back(term_t'({2'b00, 2'b01, 2'b00}));
            @(negedge clk);
            checks++; if (s_stb !== 1'b1) begin errors++; $display("FAIL to_stall%0d: got stb %b want 1", k, s_stb); end
            if (k < 7) begin
                checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL to_early%0d: got err %b want 00", k, m_err); end
            end
            tick;
        end
        s_ack = 1'b1;
        @(negedge clk);
        checks++; if ({s_cyc, s_stb} !== 2'b00) begin errors++; $display("FAIL to_abort_bus: got cyc/stb %b want 00", {s_cyc, s_stb}); end
        checks++; if ({m_ack, m_err} !== 4'b0000 || gnt !== 2'b01) begin errors++; $display("FAIL to_abort_hold: got ack=%b err=%b gnt=%b want 00/00/01", m_ack, m_err, gnt); end
        tick;
        s_ack = 1'b0;
        @(negedge clk);
        checks++; if (gnt !== 2'b01) begin errors++; $display("FAIL to_abort_stay: got %b want 01", gnt); end
        tick;
        m_cyc = '0; m_stb = '0;
        tick;
        @(negedge clk);
        checks++; if (gnt !== 2'b00) begin errors++; $display("FAIL to_release: got %b want 00", gnt); end
    endtask
`endif

    initial begin
        test_reset;
        test_single;
        test_contention;
        test_locked;
        test_reset_mid;
        test_err_rty;
        test_latency_drop;
`ifdef WBN_ARB_TIMEOUT_EN
        test_timeout;
`endif
        tick;
        tick;
        checks++; if (exp_term.size() != 0) begin errors++; $display("FAIL term_missing: got %0d pending want 0", exp_term.size()); end
        checks++; if (exp_gnt.size() != 0) begin errors++; $display("FAIL gnt_missing: got %0d pending want 0", exp_gnt.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
